// File: rtl/exe_lane_allocator_pkg.sv
// Shared definitions for the dispatch lane allocator: instruction classes,
// default lane-capability masks and index/credit typedefs.
// No logic; consumed by the allocator, its picker and the bench.
package exe_lane_allocator_pkg;

    typedef enum logic [1:0] {
        TYPE_MEMORY  = 2'd0,
        TYPE_CONTROL = 2'd1,
        TYPE_SIMPLE  = 2'd2,
        TYPE_COMPLEX = 2'd3
    } inst_type_e;

    localparam int DEF_ISSUE_WIDTH_LOG = 3;
    localparam int DEF_CREDIT_LOG      = 4;

    typedef logic [DEF_ISSUE_WIDTH_LOG-1:0] lane_idx_t;
    typedef logic [DEF_CREDIT_LOG-1:0]      credit_t;

    // Default six-lane capability map, bit l = lane l can execute the class.
    localparam logic [5:0] MASK_MEMORY  = 6'b000001;
    localparam logic [5:0] MASK_CONTROL = 6'b000010;
    localparam logic [5:0] MASK_SIMPLE  = 6'b111100;
    localparam logic [5:0] MASK_COMPLEX = 6'b001100;

    // Packed per type, type t occupies bits [t*6 +: 6].
    localparam logic [23:0] DEF_TYPE_MASK = {MASK_COMPLEX, MASK_SIMPLE, MASK_CONTROL, MASK_MEMORY};

endpackage

// File: rtl/exe_lane_allocator_lane_rr_picker.sv
// Cyclic priority encoder: first eligible lane strictly after last_i, wrapping.
// Latency: purely combinational.
// Backpressure: none; found_o low means no lane is eligible.
module lane_rr_picker
    import exe_lane_allocator_pkg::*;
#(
    parameter int N    = 6,
    parameter int LOGN = 3
) (
    input  logic [N-1:0]    elig_i,
    input  logic [LOGN-1:0] last_i,
    output logic [LOGN-1:0] lane_o,
    output logic            found_o
);

    localparam int W = LOGN + 1;

    logic [W-1:0] idx;

    // Walk last+1 .. last+N modulo N and keep the first eligible hit.
    always_comb begin
        lane_o  = '0;
        found_o = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, last_i} + W'(k + 1);
            if (idx >= W'(N)) begin
                idx = idx - W'(N);
            end
            if (!found_o && elig_i[idx[LOGN-1:0]]) begin
                found_o = 1'b1;
                lane_o  = idx[LOGN-1:0];
            end
        end
    end

endmodule

// File: rtl/exe_lane_allocator.sv
// Dispatch lane allocator: per-type round-robin lane choice under capability, active and credit limits.
// Latency: lane assignment same cycle; pointers and credits update on the next clk edge.
// Backpressure: allocStall_o high when any valid slot has no lane; nothing commits unless backEndReady_i.
module exe_lane_allocator
    import exe_lane_allocator_pkg::*;
#(
    parameter int DISPATCH_WIDTH  = 4,
    parameter int ISSUE_WIDTH     = 6,
    parameter int ISSUE_WIDTH_LOG = 3,
    parameter int NUM_TYPES       = 4,
    parameter int CREDIT_MAX      = 8,
    parameter int CREDIT_LOG      = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 recoverFlag_i,
    input  logic                                 backEndReady_i,
    input  logic [ISSUE_WIDTH-1:0]               laneActive_i,
    input  logic [NUM_TYPES*ISSUE_WIDTH-1:0]     typeMask_i,
    input  logic [DISPATCH_WIDTH-1:0]            instValid_i,
    input  logic [DISPATCH_WIDTH*2-1:0]          instTypes_i,
    input  logic [ISSUE_WIDTH-1:0]               laneRelease_i,
    output logic [DISPATCH_WIDTH*ISSUE_WIDTH_LOG-1:0] exePipes_o,
    output logic [DISPATCH_WIDTH-1:0]            isSimple_o,
    output logic                                 allocStall_o,
    output logic [ISSUE_WIDTH*CREDIT_LOG-1:0]    laneCredits_o
);

    localparam int DW  = DISPATCH_WIDTH;
    localparam int IW  = ISSUE_WIDTH;
    localparam int IWL = ISSUE_WIDTH_LOG;
    localparam int NT  = NUM_TYPES;
    localparam int CL  = CREDIT_LOG;
    localparam int CLW = CREDIT_LOG + 1;

    localparam logic [IW*CL-1:0]  CREDIT_RST = {IW{CL'(CREDIT_MAX)}};
    localparam logic [NT*IWL-1:0] PTR_RST    = {NT{IWL'(IW - 1)}};

    logic [IW*CL-1:0]  credit_q, credit_d;
    logic [NT*IWL-1:0] ptr_q, ptr_d;

    logic [DW-1:0]     slot_fail;
    logic [DW*IWL-1:0] lane_pick;
    logic [IW*CL-1:0]  avail_fin;
    logic [NT*IWL-1:0] cur_fin;
    logic              alloc_fail;
    logic              commit;
    logic [CLW-1:0]    sum;
    logic              release_at_max;
    logic              mask_missing;
    logic [IW-1:0]     mask_sel;

    // Slot chain: each stage sees the credits and pointers left by earlier slots.
    for (genvar i = 0; i < DW; i++) begin : g_slot
        logic [IW*CL-1:0]  avail_in, avail_out;
        logic [NT*IWL-1:0] cur_in, cur_out;
        logic [1:0]        ty;
        logic [IWL-1:0]    last, pick, lane_s;
        logic [IW-1:0]     type_lanes, elig;
        logic              found, fail_s;

        if (i == 0) begin : g_head
            assign avail_in = credit_q;
            assign cur_in   = ptr_q;
        end else begin : g_link
            assign avail_in = g_slot[i-1].avail_out;
            assign cur_in   = g_slot[i-1].cur_out;
        end

        assign ty = instTypes_i[2*i +: 2];

        // Select this slot's type pointer/mask and form the eligible lane set.
        always_comb begin
            last       = '0;
            type_lanes = '0;
            elig       = '0;
            for (int t = 0; t < NT; t++) begin
                if (ty == 2'(t)) begin
                    last       = cur_in[t*IWL +: IWL];
                    type_lanes = typeMask_i[t*IW +: IW];
                end
            end
            for (int l = 0; l < IW; l++) begin
                elig[l] = laneActive_i[l] & type_lanes[l] & (avail_in[l*CL +: CL] != '0);
            end
        end

        lane_rr_picker #(
            .N    (IW),
            .LOGN (IWL)
        ) u_picker (
            .elig_i  (elig),
            .last_i  (last),
            .lane_o  (pick),
            .found_o (found)
        );

        // Consume one credit on the picked lane and advance this type's cursor.
        always_comb begin
            avail_out = avail_in;
            cur_out   = cur_in;
            lane_s    = '0;
            fail_s    = 1'b0;
            if (instValid_i[i]) begin
                if (found) begin
                    lane_s = pick;
                    for (int l = 0; l < IW; l++) begin
                        if (pick == IWL'(l)) begin
                            avail_out[l*CL +: CL] = avail_in[l*CL +: CL] - CL'(1);
                        end
                    end
                    for (int t = 0; t < NT; t++) begin
                        if (ty == 2'(t)) begin
                            cur_out[t*IWL +: IWL] = pick;
                        end
                    end
                end else begin
                    fail_s = 1'b1;
                end
            end
        end

        assign slot_fail[i]            = fail_s;
        assign lane_pick[i*IWL +: IWL] = lane_s;
    end

    assign avail_fin  = g_slot[DW-1].avail_out;
    assign cur_fin    = g_slot[DW-1].cur_out;
    assign alloc_fail = |slot_fail;
    assign commit     = backEndReady_i & ~alloc_fail & ~recoverFlag_i;

    // Outputs are forced to their idle/stalled values while reset is held.
    always_comb begin
        allocStall_o = reset | alloc_fail;
        exePipes_o   = reset ? '0 : lane_pick;
        isSimple_o   = '0;
        for (int i = 0; i < DW; i++) begin
            isSimple_o[i] = ~reset & instValid_i[i] & (instTypes_i[2*i +: 2] == TYPE_SIMPLE);
        end
    end

    // Next state: flush beats commit beats release-only; credits clamp at the maximum.
    always_comb begin
        credit_d = credit_q;
        ptr_d    = ptr_q;
        sum      = '0;
        if (recoverFlag_i) begin
            credit_d = CREDIT_RST;
            ptr_d    = PTR_RST;
        end else begin
            for (int l = 0; l < IW; l++) begin
                sum = {1'b0, (commit ? avail_fin[l*CL +: CL] : credit_q[l*CL +: CL])}
                      + {{CL{1'b0}}, laneRelease_i[l]};
                credit_d[l*CL +: CL] = (sum > CLW'(CREDIT_MAX)) ? CL'(CREDIT_MAX) : sum[CL-1:0];
            end
            if (commit) begin
                ptr_d = cur_fin;
            end
        end
    end

    // Pointer and credit registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            credit_q <= CREDIT_RST;
            ptr_q    <= PTR_RST;
        end else begin
            credit_q <= credit_d;
            ptr_q    <= ptr_d;
        end
    end

    assign laneCredits_o = credit_q;

    // Protocol and configuration error detection.
    always_comb begin
        release_at_max = 1'b0;
        mask_missing   = 1'b0;
        mask_sel       = '0;
        for (int l = 0; l < IW; l++) begin
            if (laneRelease_i[l] && credit_q[l*CL +: CL] == CL'(CREDIT_MAX)) begin
                release_at_max = 1'b1;
            end
        end
        for (int i = 0; i < DW; i++) begin
            mask_sel = '0;
            for (int t = 0; t < NT; t++) begin
                if (instTypes_i[2*i +: 2] == 2'(t)) begin
                    mask_sel = typeMask_i[t*IW +: IW];
                end
            end
            if (instValid_i[i] && mask_sel == '0) begin
                mask_missing = 1'b1;
            end
        end
    end

    a_release_overflow: assert property (@(posedge clk) disable iff (reset) !release_at_max)
        else $error("lane release while credit already at maximum");

    a_empty_type_mask: assert property (@(posedge clk) disable iff (reset) !mask_missing)
        else $error("valid slot type has no capable lane");

endmodule
